l2cache_l1arbiter: RTL and testbench

- Sequencer and arbiter in front of the single request port of the shared 4-way write-back L2 cache.
- Arbitrates three requesters: Icache fetch, Dcache read/write, and cache-op (cacop) commands.
- Latches the granted request and drives it to L2 with a req/addrOK/dataOK handshake.
- Routes the L2 response back to the owning requester only, and holds one transaction outstanding at a time.

---
 rtl/l2cache_pkg.sv | 28 ++
 rtl/l2cache_arb_sel.sv | 50 +++++
 rtl/l2cache_l1arbiter.sv | 129 ++++++++++++
 tb/tb_l2cache_l1arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2cache_pkg.sv
// Shared types and constants for the L1-to-L2 request arbiter.
package l2cache_pkg;

  localparam int unsigned L1_OFFSET_WIDTH = 2;
  localparam int unsigned LINE_W          = 32 * (1 << L1_OFFSET_WIDTH);

  localparam logic [1:0] FROM_OP = 2'd0;
  localparam logic [1:0] FROM_I  = 2'd1;
  localparam logic [1:0] FROM_DR = 2'd2;
  localparam logic [1:0] FROM_DW = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  // Payload latched at grant time and held stable while the L2 owns it.
  typedef struct packed {
    logic [1:0]  from;
    logic        opflag;
    logic [31:0] opcode;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  wstrb;
  } l2_req_t;

endpackage

// File: rtl/l2cache_arb_sel.sv
// Fixed-priority requester select (op > D > I) with an Icache anti-starvation override.
module l2cache_arb_sel
  import l2cache_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       idle,
  input  logic       op_req,
  input  logic       dcache_req,
  input  logic       dcache_wr,
  input  logic       icache_req,
  output logic       grant_c,
  output logic [1:0] from_c
);

  localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = icache_req && (starve_cnt == CNT_W'(STARVE_MAX));

  always_comb begin
    grant_c = idle && (op_req || dcache_req || icache_req);
    from_c  = FROM_I;
    if (starved) begin
      from_c = FROM_I;
    end else if (op_req) begin
      from_c = FROM_OP;
    end else if (dcache_req) begin
      from_c = dcache_wr ? FROM_DW : FROM_DR;
    end
  end

  // Counts grants that bypassed a waiting Icache; only meaningful in IDLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (idle) begin
      if (!icache_req || (grant_c && from_c == FROM_I)) begin
        starve_cnt <= '0;
      end else if (grant_c && starve_cnt != CNT_W'(STARVE_MAX)) begin
        starve_cnt <= starve_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/l2cache_l1arbiter.sv
// Single-outstanding sequencer between the I/D/cacop L1 requesters and the L2 request port.
module l2cache_l1arbiter
  import l2cache_pkg::*;
#(
  parameter int unsigned L1offset_width = L1_OFFSET_WIDTH,
  parameter int unsigned STARVE_MAX     = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                icache_req,
  input  logic [31:0]                         icache_addr,
  output logic                                icache_addrOK,
  output logic                                icache_dataOK,
  output logic [32*(1<<L1offset_width)-1:0]   icache_dout,
  input  logic                                dcache_req,
  input  logic                                dcache_wr,
  input  logic [31:0]                         dcache_addr,
  input  logic [31:0]                         dcache_din,
  input  logic [3:0]                          dcache_wstrb,
  output logic                                dcache_addrOK,
  output logic                                dcache_dataOK,
  output logic [32*(1<<L1offset_width)-1:0]   dcache_dout,
  input  logic                                op_req,
  input  logic [31:0]                         op_code,
  input  logic [31:0]                         op_addr,
  output logic                                op_addrOK,
  output logic                                op_dataOK,
  output logic                                l2_req,
  output logic [1:0]                          l2_from,
  output logic                                l2_opflag,
  output logic [31:0]                         l2_opcode,
  output logic [31:0]                         l2_addr,
  output logic [31:0]                         l2_din,
  output logic [3:0]                          l2_wstrb,
  input  logic                                l2_addrOK,
  input  logic                                l2_dataOK,
  input  logic [32*(1<<L1offset_width)-1:0]   l2_dout
);

  state_t     state, next_state;
  l2_req_t    req_q, req_d;
  logic       grant;
  logic [1:0] grant_from;
  logic       addr_ok, data_ok;

  l2cache_arb_sel #(.STARVE_MAX(STARVE_MAX)) u_sel (
    .clk        (clk),
    .rst        (rst),
    .idle       (state == IDLE),
    .op_req     (op_req),
    .dcache_req (dcache_req),
    .dcache_wr  (dcache_wr),
    .icache_req (icache_req),
    .grant_c    (grant),
    .from_c     (grant_from)
  );

  // Winner's payload; fields the winner does not own are zeroed.
  always_comb begin
    req_d      = '0;
    req_d.from = grant_from;
    case (grant_from)
      FROM_OP: begin
        req_d.opflag = 1'b1;
        req_d.opcode = op_code;
        req_d.addr   = op_addr;
      end
      FROM_I:  req_d.addr = icache_addr;
      default: begin
        req_d.addr  = dcache_addr;
        req_d.din   = dcache_din;
        req_d.wstrb = dcache_wstrb;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_q <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && grant) req_q <= req_d;
    end
  end

  // L2 handshakes outside ISSUE/WAIT never reach a requester.
  always_comb begin
    next_state = state;
    addr_ok    = 1'b0;
    data_ok    = 1'b0;
    case (state)
      IDLE:  if (grant) next_state = ISSUE;
      ISSUE: begin
        if (l2_addrOK) begin
          addr_ok    = 1'b1;
          data_ok    = l2_dataOK;
          next_state = l2_dataOK ? IDLE : WAIT;
        end
      end
      WAIT: begin
        if (l2_dataOK) begin
          data_ok    = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign op_addrOK     = addr_ok && (req_q.from == FROM_OP);
  assign icache_addrOK = addr_ok && (req_q.from == FROM_I);
  assign dcache_addrOK = addr_ok && req_q.from[1];
  assign op_dataOK     = data_ok && (req_q.from == FROM_OP);
  assign icache_dataOK = data_ok && (req_q.from == FROM_I);
  assign dcache_dataOK = data_ok && req_q.from[1];

  assign icache_dout = l2_dout;
  assign dcache_dout = l2_dout;

  assign l2_req    = (state == ISSUE);
  assign l2_from   = req_q.from;
  assign l2_opflag = req_q.opflag;
  assign l2_opcode = req_q.opcode;
  assign l2_addr   = req_q.addr;
  assign l2_din    = req_q.din;
  assign l2_wstrb  = req_q.wstrb;

endmodule

// File: tb/tb_l2cache_l1arbiter.sv
// Table-driven bench for l2cache_l1arbiter; the bench plays the L2 and checks grants from a scoreboard.
module tb_l2cache_l1arbiter;
  import l2cache_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         icache_req, dcache_req, dcache_wr, op_req;
  logic [31:0]  icache_addr, dcache_addr, dcache_din, op_code, op_addr;
  logic [3:0]   dcache_wstrb;
  logic         icache_addrOK, icache_dataOK, dcache_addrOK, dcache_dataOK, op_addrOK, op_dataOK;
  logic [127:0] icache_dout, dcache_dout, l2_dout;
  logic         l2_req, l2_opflag, l2_addrOK, l2_dataOK;
  logic [1:0]   l2_from;
  logic [31:0]  l2_opcode, l2_addr, l2_din;
  logic [3:0]   l2_wstrb;

  l2cache_l1arbiter #(.L1offset_width(2), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr), .icache_addrOK(icache_addrOK),
    .icache_dataOK(icache_dataOK), .icache_dout(icache_dout),
    .dcache_req(dcache_req), .dcache_wr(dcache_wr), .dcache_addr(dcache_addr),
    .dcache_din(dcache_din), .dcache_wstrb(dcache_wstrb), .dcache_addrOK(dcache_addrOK),
    .dcache_dataOK(dcache_dataOK), .dcache_dout(dcache_dout),
    .op_req(op_req), .op_code(op_code), .op_addr(op_addr), .op_addrOK(op_addrOK),
    .op_dataOK(op_dataOK),
    .l2_req(l2_req), .l2_from(l2_from), .l2_opflag(l2_opflag), .l2_opcode(l2_opcode),
    .l2_addr(l2_addr), .l2_din(l2_din), .l2_wstrb(l2_wstrb),
    .l2_addrOK(l2_addrOK), .l2_dataOK(l2_dataOK), .l2_dout(l2_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  from;
    logic        opflag;
    logic [31:0] opcode;
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  wstrb;
  } exp_t;

  typedef struct {
    logic [1:0]   src;
    logic [31:0]  addr;
    logic [31:0]  din;
    logic [3:0]   wstrb;
    logic [31:0]  opcode;
    int           aok_lat;
    int           dok_lat;
    bit           both;
    logic [127:0] line;
    exp_t         exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   n_vec  = 0;
  int   n_fail = 0;

  localparam logic [127:0] LINE_A = 128'h11112222_33334444_55556666_777777AA;
  localparam logic [127:0] LINE_B = 128'hCAFEF00D_0BADBEEF_12345678_9ABCDEF0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  function automatic exp_t mke(input logic [1:0] from, input logic opflag, input logic [31:0] opcode,
                               input logic [31:0] addr, input logic [31:0] din, input logic [3:0] wstrb);
    exp_t e;
    e.from = from; e.opflag = opflag; e.opcode = opcode;
    e.addr = addr; e.din = din; e.wstrb = wstrb;
    return e;
  endfunction

  function automatic vec_t mkv(input logic [1:0] src, input logic [31:0] addr, input logic [31:0] din,
                               input logic [3:0] wstrb, input logic [31:0] opcode, input int aok_lat,
                               input int dok_lat, input bit both, input logic [127:0] line, input exp_t e);
    vec_t v;
    v.src = src; v.addr = addr; v.din = din; v.wstrb = wstrb; v.opcode = opcode;
    v.aok_lat = aok_lat; v.dok_lat = dok_lat; v.both = both; v.line = line; v.exp = e;
    return v;
  endfunction

  task automatic drive(input logic [1:0] src, input logic [31:0] addr, input logic [31:0] din,
                       input logic [3:0] wstrb, input logic [31:0] opcode);
    case (src)
      2'd0: begin op_req = 1'b1; op_addr = addr; op_code = opcode; end
      2'd1: begin icache_req = 1'b1; icache_addr = addr; end
      default: begin
        dcache_req = 1'b1; dcache_wr = (src == 2'd3);
        dcache_addr = addr; dcache_din = din; dcache_wstrb = wstrb;
      end
    endcase
  endtask

  task automatic clear_req(input logic [1:0] src);
    case (src)
      2'd0:    op_req = 1'b0;
      2'd1:    icache_req = 1'b0;
      default: dcache_req = 1'b0;
    endcase
  endtask

  // Acts as the L2 for one transaction. drop: 0 keep req, 1 drop at addrOK, 2 drop as soon as issued.
  task automatic serve(input int exp_lat, input int aok_lat, input int dok_lat, input bit both,
                       input logic [127:0] line, input int drop);
    int waited = 0;
    exp_t e;
    logic [2:0] own;
    while (!l2_req && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!l2_req) begin
      check("issue_timeout", 128'(l2_req), 128'(1));
      return;
    end
    check("issue_latency", 128'(waited), 128'(exp_lat));
    if (sb.size() == 0) begin
      check("scoreboard_empty", 128'(0), 128'(1));
      return;
    end
    e = sb.pop_front();
    check("l2_from", 128'(l2_from), 128'(e.from));
    check("l2_addr", 128'(l2_addr), 128'(e.addr));
    check("l2_din", 128'(l2_din), 128'(e.din));
    check("l2_wstrb", 128'(l2_wstrb), 128'(e.wstrb));
    check("l2_opflag", 128'(l2_opflag), 128'(e.opflag));
    check("l2_opcode", 128'(l2_opcode), 128'(e.opcode));
    own = (e.from == 2'd0) ? 3'b100 : (e.from == 2'd1) ? 3'b001 : 3'b010;
    if (drop == 2) clear_req(e.from);
    repeat (aok_lat) begin
      check("addrok_early", 128'({op_addrOK, dcache_addrOK, icache_addrOK}), 128'(0));
      @(posedge clk); #1;
      check("l2_req_held", 128'(l2_req), 128'(1));
      check("l2_addr_stable", 128'(l2_addr), 128'(e.addr));
    end
    l2_addrOK = 1'b1;
    l2_dout   = line;
    if (both) l2_dataOK = 1'b1;
    #1;
    check("addrok_owner", 128'({op_addrOK, dcache_addrOK, icache_addrOK}), 128'(own));
    if (both) begin
      check("dataok_with_addrok", 128'({op_dataOK, dcache_dataOK, icache_dataOK}), 128'(own));
      check("icache_dout", icache_dout, line);
      check("dcache_dout", dcache_dout, line);
    end else begin
      check("dataok_early", 128'({op_dataOK, dcache_dataOK, icache_dataOK}), 128'(0));
    end
    @(posedge clk); #1;
    l2_addrOK = 1'b0;
    l2_dataOK = 1'b0;
    if (drop == 1) clear_req(e.from);
    check("l2_req_after_accept", 128'(l2_req), 128'(0));
    if (!both) begin
      repeat (dok_lat) begin
        check("dataok_wait", 128'({op_dataOK, dcache_dataOK, icache_dataOK}), 128'(0));
        @(posedge clk); #1;
      end
      l2_dataOK = 1'b1;
      l2_dout   = line;
      #1;
      check("dataok_owner", 128'({op_dataOK, dcache_dataOK, icache_dataOK}), 128'(own));
      check("icache_dout", icache_dout, line);
      check("dcache_dout", dcache_dout, line);
      @(posedge clk); #1;
      l2_dataOK = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1;
    icache_req = 0; dcache_req = 0; dcache_wr = 0; op_req = 0;
    icache_addr = 0; dcache_addr = 0; dcache_din = 0; dcache_wstrb = 0; op_code = 0; op_addr = 0;
    l2_addrOK = 0; l2_dataOK = 0; l2_dout = '0;

    vecs[0] = mkv(2'd1, 32'h1C000040, 32'h0, 4'h0, 32'h0, 1, 2, 1'b0, LINE_A,
                  mke(2'd1, 1'b0, 32'h0, 32'h1C000040, 32'h0, 4'h0));
    vecs[1] = mkv(2'd3, 32'h00000104, 32'hDEADBEEF, 4'h3, 32'h0, 0, 1, 1'b0, LINE_B,
                  mke(2'd3, 1'b0, 32'h0, 32'h00000104, 32'hDEADBEEF, 4'h3));
    vecs[2] = mkv(2'd0, 32'h80000000, 32'h0, 4'h0, 32'h00000013, 2, 0, 1'b0, LINE_A,
                  mke(2'd0, 1'b1, 32'h00000013, 32'h80000000, 32'h0, 4'h0));
    vecs[3] = mkv(2'd2, 32'h00002000, 32'h5555AAAA, 4'hF, 32'h0, 0, 0, 1'b1, LINE_B,
                  mke(2'd2, 1'b0, 32'h0, 32'h00002000, 32'h5555AAAA, 4'hF));
    vecs[4] = mkv(2'd1, 32'h1C000080, 32'h0, 4'h0, 32'h0, 0, 0, 1'b1, LINE_A,
                  mke(2'd1, 1'b0, 32'h0, 32'h1C000080, 32'h0, 4'h0));

    repeat (2) @(posedge clk);
    #1;
    check("rst_l2_req", 128'(l2_req), 128'(0));
    check("rst_l2_payload", 128'({l2_from, l2_opflag, l2_opcode, l2_addr, l2_din, l2_wstrb}), 128'(0));
    check("rst_handshakes", 128'({icache_addrOK, icache_dataOK, dcache_addrOK, dcache_dataOK,
                                  op_addrOK, op_dataOK}), 128'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Single-requester transactions from the table.
    foreach (vecs[i]) begin
      drive(vecs[i].src, vecs[i].addr, vecs[i].din, vecs[i].wstrb, vecs[i].opcode);
      sb.push_back(vecs[i].exp);
      serve(1, vecs[i].aok_lat, vecs[i].dok_lat, vecs[i].both, vecs[i].line, 1);
    end

    // Simultaneous I and D read: D first, then I on the following IDLE.
    drive(2'd1, 32'h1C000200, 32'h0, 4'h0, 32'h0);
    drive(2'd2, 32'h00004000, 32'h0, 4'h0, 32'h0);
    sb.push_back(mke(2'd2, 1'b0, 32'h0, 32'h00004000, 32'h0, 4'h0));
    sb.push_back(mke(2'd1, 1'b0, 32'h0, 32'h1C000200, 32'h0, 4'h0));
    serve(1, 0, 1, 1'b0, LINE_B, 1);
    serve(1, 0, 0, 1'b0, LINE_A, 1);

    // Requester withdraws before its addrOK; the latched grant still completes.
    drive(2'd1, 32'h1C000300, 32'h0, 4'h0, 32'h0);
    sb.push_back(mke(2'd1, 1'b0, 32'h0, 32'h1C000300, 32'h0, 4'h0));
    serve(1, 2, 1, 1'b0, LINE_B, 2);

    // L2 handshakes in IDLE are ignored.
    l2_addrOK = 1'b1; l2_dataOK = 1'b1;
    #1;
    check("idle_ignore", 128'({icache_addrOK, icache_dataOK, dcache_addrOK, dcache_dataOK,
                               op_addrOK, op_dataOK}), 128'(0));
    @(posedge clk); #1;
    check("idle_stays", 128'(l2_req), 128'(0));
    l2_addrOK = 1'b0; l2_dataOK = 1'b0;

    // Starvation: eight D grants while I waits, then I is forced through.
    drive(2'd1, 32'h1C000100, 32'h0, 4'h0, 32'h0);
    drive(2'd2, 32'h00003000, 32'h0, 4'h0, 32'h0);
    for (int k = 0; k < 8; k++) sb.push_back(mke(2'd2, 1'b0, 32'h0, 32'h00003000, 32'h0, 4'h0));
    sb.push_back(mke(2'd1, 1'b0, 32'h0, 32'h1C000100, 32'h0, 4'h0));
    for (int k = 0; k < 8; k++) serve(1, 0, 0, 1'b1, LINE_B, 0);
    serve(1, 0, 0, 1'b0, LINE_A, 1);
    dcache_req = 1'b0;

    // Reset while an op transaction sits in WAIT.
    drive(2'd0, 32'h00000040, 32'h0, 4'h0, 32'h0000000A);
    sb.push_back(mke(2'd0, 1'b1, 32'h0000000A, 32'h00000040, 32'h0, 4'h0));
    @(posedge clk); #1;
    check("op_issue", 128'({l2_req, l2_from, l2_opflag, l2_opcode}), 128'({1'b1, 2'd0, 1'b1, 32'h0000000A}));
    void'(sb.pop_front());
    l2_addrOK = 1'b1;
    #1;
    check("op_addrok", 128'(op_addrOK), 128'(1));
    @(posedge clk); #1;
    l2_addrOK = 1'b0;
    op_req = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    l2_dout = '0;
    check("wait_rst_l2_req", 128'(l2_req), 128'(0));
    check("wait_rst_payload", 128'({l2_from, l2_opflag, l2_opcode, l2_addr, l2_din, l2_wstrb}), 128'(0));
    l2_dataOK = 1'b1;
    #1;
    check("stale_op_dataok", 128'({op_dataOK, icache_dataOK, dcache_dataOK}), 128'(0));
    @(posedge clk); #1;
    l2_dataOK = 1'b0;
    check("post_rst_idle", 128'(l2_req), 128'(0));

    // Recovery after reset.
    drive(2'd1, 32'h1C000400, 32'h0, 4'h0, 32'h0);
    sb.push_back(mke(2'd1, 1'b0, 32'h0, 32'h1C000400, 32'h0, 4'h0));
    serve(1, 0, 0, 1'b0, LINE_A, 1);
    check("scoreboard_drained", 128'(sb.size()), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
